// File: rtl/fixed_to_fp.sv
// Signed 3.16 fixed-point to IEEE-754 single-precision converter with valid/ready handshakes.
// Build option FIXED_TO_FP_FAST_NORM_EN: single-cycle priority-encoder normalization instead of the iterative shifter.
module fixed_to_fp (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    // state | meaning
    // IDLE  | waiting for a sample, in_ready high
    // NORM  | normalizing the magnitude, k counts left shifts
    // OUT   | result held in out_data until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        sign, sign_nxt;
    logic [18:0] mag, mag_nxt;
    logic [4:0]  k, k_nxt;
    logic [31:0] out_data_nxt;

`ifdef FIXED_TO_FP_FAST_NORM_EN
    logic [4:0]  lz;
    logic [18:0] mag_norm;

    function automatic logic [4:0] lead_zeros(input logic [18:0] v);
        logic [4:0] n;
        n = 5'd19;
        for (int i = 0; i < 19; i++) begin
            if (v[i]) n = 5'(18 - i);
        end
        return n;
    endfunction
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sign     <= 1'b0;
            mag      <= '0;
            k        <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            sign     <= sign_nxt;
            mag      <= mag_nxt;
            k        <= k_nxt;
            out_data <= out_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sign_nxt     = sign;
        mag_nxt      = mag;
        k_nxt        = k;
        out_data_nxt = out_data;
`ifdef FIXED_TO_FP_FAST_NORM_EN
        lz       = lead_zeros(mag);
        mag_norm = mag << lz;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt  = in_data[18];
                    // -4.0 negates to itself, which reads correctly as unsigned 0x40000
                    mag_nxt   = in_data[18] ? 19'(-in_data) : in_data;
                    k_nxt     = '0;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (mag == '0) begin
                    // zero is always +0, whatever the sign bit
                    out_data_nxt = '0;
                    state_nxt    = OUT;
                end
`ifdef FIXED_TO_FP_FAST_NORM_EN
                else begin
                    k_nxt        = lz;
                    mag_nxt      = mag_norm;
                    out_data_nxt = {sign, 8'd129 - {3'b000, lz}, mag_norm[17:0], 5'b00000};
                    state_nxt    = OUT;
                end
`else
                else if (!mag[18]) begin
                    mag_nxt = mag << 1;
                    k_nxt   = k + 5'd1;
                end else begin
                    out_data_nxt = {sign, 8'd129 - {3'b000, k}, mag[17:0], 5'b00000};
                    state_nxt    = OUT;
                end
`endif
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fixed_to_fp.sv
// Scoreboard bench for fixed_to_fp: expected results and latencies are queued at send time, compared on out_valid.
module tb_fixed_to_fp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    fixed_to_fp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic int lat_of(input int iterative);
`ifdef FIXED_TO_FP_FAST_NORM_EN
        return 1;
`else
        return iterative;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a sample until it is accepted, then scramble in_data
    task automatic send(input logic [18:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        in_data  = 19'($urandom);
    endtask

    task automatic collect(input string name);
        int          lat;
        logic [31:0] ed;
        int          el;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        ed = exp_q.pop_front();
        el = lat_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
        end else begin
            n_checks++;
            if (out_data !== ed) begin
                n_fail++;
                $display("FAIL %s data: got %08h, required %08h", name, out_data, ed);
            end
            n_checks++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL %s latency: got %0d, required %0d", name, lat, el);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 19'h10000; out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset out_data: got %08h, required 00000000", out_data); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset no_capture: in_ready=%b, required 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [18:0] vin  [11] = '{19'h10000, 19'h40000, 19'h70000, 19'h3243F, 19'h00001, 19'h00000,
                                   19'h3FFFF, 19'h7FFFF, 19'h08000, 19'h18000, 19'h60000};
        logic [31:0] vexp [11] = '{32'h3F800000, 32'hC0800000, 32'hBF800000, 32'h40490FC0, 32'h37800000,
                                   32'h00000000, 32'h407FFFC0, 32'hB7800000, 32'h3F000000, 32'h3FC00000,
                                   32'hC0000000};
        int          vlat [11] = '{3, 1, 3, 2, 19, 1, 2, 19, 4, 3, 2};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vexp[i]);
            lat_q.push_back(vin[i] == 19'h0 ? 1 : lat_of(vlat[i]));
            send(vin[i]);
            collect($sformatf("vec_%05h", vin[i]));
            tick();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_%05h return_idle: in_ready=%b out_valid=%b, required 1/0", vin[i], in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        out_ready = 1'b0;
        exp_q.push_back(32'h3F800000);
        lat_q.push_back(lat_of(3));
        send(19'h10000);
        collect("bp_first");
        held = 32'h3F800000;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            in_data  = 19'h20000;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b out_data=%08h, required 1/0/%08h",
                         c, out_valid, in_ready, out_data, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_capture: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(19'h00001);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b out_data=%08h, required 1/0/00000000",
                     in_ready, out_valid, out_data);
        end
        exp_q.push_back(32'h3F800000);
        lat_q.push_back(lat_of(3));
        send(19'h10000);
        collect("rst_mid_after");
        tick();
    endtask

    task automatic test_back_to_back();
        int   nacc, nout, idle_cnt;
        logic will_acc;
        nacc = 0; nout = 0; idle_cnt = 0;
        out_ready = 1'b1;
        exp_q.push_back(32'h3F800000);
        exp_q.push_back(32'hBF800000);
        in_data  = 19'h10000;
        in_valid = 1'b1;
        for (int c = 0; c < 40 && nout < 2; c++) begin
            if (out_valid) begin
                logic [31:0] ed;
                ed = exp_q.pop_front();
                n_checks++;
                if (out_data !== ed) begin
                    n_fail++;
                    $display("FAIL b2b result %0d: got %08h, required %08h", nout, out_data, ed);
                end
                nout++;
            end
            will_acc = in_ready && in_valid;
            if (in_ready && nout == 1) idle_cnt++;
            tick();
            if (will_acc) begin
                nacc++;
                if (nacc == 1) in_data = 19'h70000;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (nout !== 2 || nacc !== 2) begin
            n_fail++;
            $display("FAIL b2b count: results=%0d accepts=%0d, required 2/2", nout, nacc);
        end
        n_checks++;
        if (idle_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b idle_gap: got %0d cycles, required 1", idle_cnt);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
